// File: rtl/seq_alu.sv
// seq_alu -- EX-stage ALU with an iterative unsigned multiply/divide unit.
//
// Combinational ops (AND/OR/ADD/SUB/SLT/NOR/MFHI/MFLO) settle in the same
// cycle on ALU_OUT/Zero. MULTU and DIVU run one bit per cycle for WIDTH
// cycles behind a start/busy/done handshake and write the HI/LO registers.
//
// Ports:
//   clk      rising-edge clock
//   reset    synchronous, active-high reset
//   ALUIN1   operand A (dividend / multiplicand)
//   ALUIN2   operand B (divisor / multiplier)
//   ALUC     operation select
//   start    launches MULTU/DIVU when selected and the unit is idle
//   ALU_OUT  combinational result
//   Zero     high when ALU_OUT == 0
//   HI, LO   product upper/lower half, or remainder/quotient
//   busy     multi-cycle operation in progress
//   done     one-cycle pulse on the edge HI/LO are written
module seq_alu #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] ALUIN1,
  input  logic [WIDTH-1:0] ALUIN2,
  input  logic [3:0]       ALUC,
  input  logic             start,
  output logic [WIDTH-1:0] ALU_OUT,
  output logic             Zero,
  output logic [WIDTH-1:0] HI,
  output logic [WIDTH-1:0] LO,
  output logic             busy,
  output logic             done
);

  localparam int CW = $clog2(WIDTH + 1);

  localparam logic [3:0] OP_AND   = 4'b0000;
  localparam logic [3:0] OP_OR    = 4'b0001;
  localparam logic [3:0] OP_ADD   = 4'b0010;
  localparam logic [3:0] OP_SUB   = 4'b0110;
  localparam logic [3:0] OP_SLT   = 4'b0111;
  localparam logic [3:0] OP_SUBB  = 4'b1000;
  localparam logic [3:0] OP_MULTU = 4'b1001;
  localparam logic [3:0] OP_DIVU  = 4'b1010;
  localparam logic [3:0] OP_NOR   = 4'b1100;
  localparam logic [3:0] OP_MFHI  = 4'b1101;
  localparam logic [3:0] OP_MFLO  = 4'b1110;

  typedef enum logic [1:0] {IDLE, MUL, DIV, FIN} state_t;

  state_t             state_reg;
  logic [CW-1:0]      count_reg;
  logic [WIDTH-1:0]   opd_reg;     // multiplicand for MUL, divisor for DIV
  logic [2*WIDTH-1:0] acc_reg;     // {upper, lower} working accumulator
  logic [WIDTH-1:0]   hi_reg;
  logic [WIDTH-1:0]   lo_reg;
  logic               busy_reg;
  logic               done_reg;

  // ---------------- combinational ALU ----------------
  logic [WIDTH-1:0] alu_result;
  logic             slt_bit;

  assign slt_bit = ($signed(ALUIN1) < $signed(ALUIN2));

  always_comb begin
    alu_result = '0;
    case (ALUC)
      OP_AND:          alu_result = ALUIN1 & ALUIN2;
      OP_OR:           alu_result = ALUIN1 | ALUIN2;
      OP_ADD:          alu_result = ALUIN1 + ALUIN2;
      OP_SUB, OP_SUBB: alu_result = ALUIN1 - ALUIN2;
      OP_SLT:          alu_result = {{(WIDTH-1){1'b0}}, slt_bit};
      OP_NOR:          alu_result = ~(ALUIN1 | ALUIN2);
      OP_MFHI:         alu_result = hi_reg;
      OP_MFLO:         alu_result = lo_reg;
      default:         alu_result = '0;
    endcase
  end

  assign ALU_OUT = alu_result;
  assign Zero    = ~|alu_result;

  // ---------------- iterative step logic ----------------
  // Multiply: the multiplier sits in the low half and is consumed LSB first;
  // the partial product grows in the high half and shifts right each step.
  logic [WIDTH:0]     mul_sum;
  logic [2*WIDTH-1:0] mul_next;
  // Divide: the dividend sits in the low half and is shifted out MSB first
  // into the remainder; quotient bits shift in from the right.
  logic [WIDTH:0]     div_shift;
  logic [WIDTH:0]     div_diff;
  logic [2*WIDTH-1:0] div_next;
  logic [2*WIDTH-1:0] step_next;

  always_comb begin
    mul_sum  = {1'b0, acc_reg[2*WIDTH-1:WIDTH]} +
               {1'b0, (acc_reg[0] ? opd_reg : {WIDTH{1'b0}})};
    mul_next = {mul_sum, acc_reg[WIDTH-1:1]};

    div_shift = {acc_reg[2*WIDTH-1:WIDTH], acc_reg[WIDTH-1]};
    div_diff  = div_shift - {1'b0, opd_reg};
    // Remainder stays below the divisor, so a set MSB on the difference
    // means the trial subtraction borrowed and must be discarded.
    if (!div_diff[WIDTH])
      div_next = {div_diff[WIDTH-1:0], acc_reg[WIDTH-2:0], 1'b1};
    else
      div_next = {div_shift[WIDTH-1:0], acc_reg[WIDTH-2:0], 1'b0};

    step_next = (state_reg == MUL) ? mul_next : div_next;
  end

  // ---------------- control FSM ----------------
  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg <= IDLE;
      count_reg <= '0;
      opd_reg   <= '0;
      acc_reg   <= '0;
      hi_reg    <= '0;
      lo_reg    <= '0;
      busy_reg  <= 1'b0;
      done_reg  <= 1'b0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (start && ALUC == OP_MULTU) begin
            state_reg <= MUL;
            busy_reg  <= 1'b1;
            opd_reg   <= ALUIN1;
            acc_reg   <= {{WIDTH{1'b0}}, ALUIN2};
            count_reg <= CW'(WIDTH);
          end else if (start && ALUC == OP_DIVU) begin
            if (ALUIN2 == '0) begin
              // Divide by zero resolves immediately without going busy.
              state_reg <= FIN;
              done_reg  <= 1'b1;
              hi_reg    <= ALUIN1;
              lo_reg    <= '1;
            end else begin
              state_reg <= DIV;
              busy_reg  <= 1'b1;
              opd_reg   <= ALUIN2;
              acc_reg   <= {{WIDTH{1'b0}}, ALUIN1};
              count_reg <= CW'(WIDTH);
            end
          end
        end
        MUL, DIV: begin
          acc_reg   <= step_next;
          count_reg <= count_reg - CW'(1);
          if (count_reg == CW'(1)) begin
            // Final step result goes straight into HI/LO on this edge.
            state_reg <= FIN;
            busy_reg  <= 1'b0;
            done_reg  <= 1'b1;
            hi_reg    <= step_next[2*WIDTH-1:WIDTH];
            lo_reg    <= step_next[WIDTH-1:0];
          end
        end
        FIN: begin
          state_reg <= IDLE;
          done_reg  <= 1'b0;
        end
      endcase
    end
  end

  assign HI   = hi_reg;
  assign LO   = lo_reg;
  assign busy = busy_reg;
  assign done = done_reg;

endmodule

// File: tb/tb_seq_alu.sv
// Testbench for seq_alu: drives a 32-bit and an 8-bit instance, checks the
// combinational ops from a vector table and random stimulus, and checks the
// multi-cycle MULTU/DIVU handshake against a plain-arithmetic reference.
module tb_seq_alu;

  logic        clk = 1'b0;
  logic        reset;
  logic [3:0]  alu_c;
  logic [31:0] a_in, b_in;
  logic        start32, start8;

  logic [31:0] out32, hi32, lo32;
  logic        zero32, busy32, done32;
  logic [7:0]  out8, hi8, lo8;
  logic        zero8, busy8, done8;

  int checks = 0;
  int errors = 0;

  logic [31:0] hi_m [2];
  logic [31:0] lo_m [2];

  always #5 clk = ~clk;

  seq_alu #(.WIDTH(32)) dut32 (
    .clk(clk), .reset(reset), .ALUIN1(a_in), .ALUIN2(b_in), .ALUC(alu_c),
    .start(start32), .ALU_OUT(out32), .Zero(zero32), .HI(hi32), .LO(lo32),
    .busy(busy32), .done(done32)
  );

  seq_alu #(.WIDTH(8)) dut8 (
    .clk(clk), .reset(reset), .ALUIN1(a_in[7:0]), .ALUIN2(b_in[7:0]), .ALUC(alu_c),
    .start(start8), .ALU_OUT(out8), .Zero(zero8), .HI(hi8), .LO(lo8),
    .busy(busy8), .done(done8)
  );

  typedef struct {
    logic [3:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] exp_out;
    logic        exp_zero;
  } vec_t;

  vec_t vecs [13];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic get_busy(input bit w8);
    return w8 ? busy8 : busy32;
  endfunction
  function automatic logic get_done(input bit w8);
    return w8 ? done8 : done32;
  endfunction
  function automatic logic [31:0] get_hi(input bit w8);
    return w8 ? {24'h0, hi8} : hi32;
  endfunction
  function automatic logic [31:0] get_lo(input bit w8);
    return w8 ? {24'h0, lo8} : lo32;
  endfunction
  function automatic logic [31:0] get_out(input bit w8);
    return w8 ? {24'h0, out8} : out32;
  endfunction

  // Reference for the combinational ops, from the op definitions.
  function automatic logic [31:0] exp_alu(input bit w8, input logic [3:0] op,
                                          input logic [31:0] a, input logic [31:0] b,
                                          input logic [31:0] hi, input logic [31:0] lo);
    logic [31:0] mask, r;
    logic lt;
    mask = w8 ? 32'h0000_00FF : 32'hFFFF_FFFF;
    lt = w8 ? ($signed(a[7:0]) < $signed(b[7:0])) : ($signed(a) < $signed(b));
    case (op)
      4'h0:       r = a & b;
      4'h1:       r = a | b;
      4'h2:       r = a + b;
      4'h6, 4'h8: r = a - b;
      4'h7:       r = {31'h0, lt};
      4'hC:       r = ~(a | b);
      4'hD:       r = hi;
      4'hE:       r = lo;
      default:    r = 32'h0;
    endcase
    return r & mask;
  endfunction

  // mode 0: plain; 1: change operands mid-op; 2: second start (DIVU) mid-op
  task automatic run_op(input bit w8, input logic [3:0] op, input logic [31:0] a,
                        input logic [31:0] b, input int mode);
    int w, cnt, exp_busy;
    logic [63:0] am, bm, p;
    logic [31:0] mask, ehi, elo;
    w    = w8 ? 8 : 32;
    mask = w8 ? 32'h0000_00FF : 32'hFFFF_FFFF;
    am   = {32'h0, a & mask};
    bm   = {32'h0, b & mask};
    if (op == 4'h9) begin
      p   = am * bm;
      ehi = 32'(p >> w) & mask;
      elo = 32'(p) & mask;
      exp_busy = w;
    end else if (bm == 64'h0) begin
      elo = mask;
      ehi = 32'(am);
      exp_busy = 0;
    end else begin
      elo = 32'(am / bm);
      ehi = 32'(am % bm);
      exp_busy = w;
    end

    alu_c = op; a_in = a; b_in = b;
    if (w8) start8 = 1'b1; else start32 = 1'b1;
    tick();
    start8 = 1'b0; start32 = 1'b0;

    cnt = 0;
    while (get_busy(w8) && cnt < 200) begin
      cnt++;
      check("done_low_while_busy", {31'h0, get_done(w8)}, 32'h0);
      if (cnt == 2) begin
        alu_c = 4'hD;
        #1;
        check("mfhi_old_during_busy", get_out(w8), hi_m[w8]);
      end
      if (mode == 1 && cnt == 5) begin
        a_in = $urandom; b_in = $urandom;
      end
      if (mode == 2 && cnt == 5) begin
        alu_c = 4'hA; a_in = 32'd100; b_in = 32'd7;
        if (w8) start8 = 1'b1; else start32 = 1'b1;
      end
      if (mode == 2 && cnt == 6) begin
        start8 = 1'b0; start32 = 1'b0;
      end
      tick();
    end
    start8 = 1'b0; start32 = 1'b0;

    check("busy_cycles", 32'(cnt), 32'(exp_busy));
    check("done_pulse", {31'h0, get_done(w8)}, 32'h1);
    check("hi_result", get_hi(w8), ehi);
    check("lo_result", get_lo(w8), elo);
    hi_m[w8] = ehi;
    lo_m[w8] = elo;
    tick();
    check("done_one_cycle", {31'h0, get_done(w8)}, 32'h0);
    alu_c = 4'hE;
    #1;
    check("mflo_after", get_out(w8), elo);
    $display("op w=%0d alu_c=%h a=%h b=%h busy_cycles=%0d hi=%h lo=%h",
             w, op, a & mask, b & mask, cnt, get_hi(w8), get_lo(w8));
  endtask

  initial begin
    vecs[0]  = '{4'h2, 32'h7FFF_FFFF, 32'h1,         32'h8000_0000, 1'b0};
    vecs[1]  = '{4'h8, 32'h5,         32'h5,         32'h0,         1'b1};
    vecs[2]  = '{4'h6, 32'h5,         32'h5,         32'h0,         1'b1};
    vecs[3]  = '{4'h7, 32'hFFFF_FFFF, 32'h1,         32'h1,         1'b0};
    vecs[4]  = '{4'h7, 32'h1,         32'hFFFF_FFFF, 32'h0,         1'b1};
    vecs[5]  = '{4'hC, 32'h0,         32'h0,         32'hFFFF_FFFF, 1'b0};
    vecs[6]  = '{4'h0, 32'hF0F0,      32'hFF00,      32'hF000,      1'b0};
    vecs[7]  = '{4'h1, 32'hF0F0,      32'h0F0F,      32'hFFFF,      1'b0};
    vecs[8]  = '{4'h9, 32'h3,         32'h4,         32'h0,         1'b1};
    vecs[9]  = '{4'hA, 32'h3,         32'h4,         32'h0,         1'b1};
    vecs[10] = '{4'hF, 32'h3,         32'h4,         32'h0,         1'b1};
    vecs[11] = '{4'hD, 32'h1,         32'h2,         32'h0,         1'b1};
    vecs[12] = '{4'h2, 32'hFFFF_FFFF, 32'h1,         32'h0,         1'b1};

    reset = 1'b1; start32 = 1'b0; start8 = 1'b0;
    alu_c = 4'h0; a_in = 32'h0; b_in = 32'h0;
    for (int i = 0; i < 2; i++) begin
      hi_m[i] = 32'h0; lo_m[i] = 32'h0;
    end
    tick(); tick();
    reset = 1'b0;
    check("rst_busy32", {31'h0, busy32}, 32'h0);
    check("rst_done32", {31'h0, done32}, 32'h0);
    check("rst_hi32", hi32, 32'h0);
    check("rst_lo32", lo32, 32'h0);
    check("rst_busy8", {31'h0, busy8}, 32'h0);
    check("rst_hi8", {24'h0, hi8}, 32'h0);

    // Table-driven combinational vectors
    for (int i = 0; i < 13; i++) begin
      alu_c = vecs[i].op; a_in = vecs[i].a; b_in = vecs[i].b;
      #1;
      check("vec_out", out32, vecs[i].exp_out);
      check("vec_zero", {31'h0, zero32}, {31'h0, vecs[i].exp_zero});
      $display("vec %0d alu_c=%h a=%h b=%h out=%h zero=%b",
               i, vecs[i].op, vecs[i].a, vecs[i].b, out32, zero32);
    end
    tick();

    // Multi-cycle corner cases, 32-bit
    run_op(1'b0, 4'h9, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0);
    check("mul_max_hi", hi32, 32'hFFFF_FFFE);
    check("mul_max_lo", lo32, 32'h0000_0001);
    alu_c = 4'hD; #1;
    check("mfhi_max", out32, 32'hFFFF_FFFE);

    run_op(1'b0, 4'hA, 32'd100, 32'd7, 1);
    check("div_100_7_lo", lo32, 32'd14);
    check("div_100_7_hi", hi32, 32'd2);

    run_op(1'b0, 4'hA, 32'h1234, 32'h0, 0);
    check("div0_lo", lo32, 32'hFFFF_FFFF);
    check("div0_hi", hi32, 32'h1234);

    run_op(1'b0, 4'h9, 32'd3, 32'd4, 2);
    check("mul_3_4_lo", lo32, 32'd12);
    check("mul_3_4_hi", hi32, 32'd0);

    // Reset mid-operation aborts with no write and no done
    alu_c = 4'h9; a_in = 32'd3; b_in = 32'd5; start32 = 1'b1;
    tick();
    start32 = 1'b0;
    repeat (9) tick();
    reset = 1'b1;
    tick();
    check("midrst_busy", {31'h0, busy32}, 32'h0);
    check("midrst_done", {31'h0, done32}, 32'h0);
    check("midrst_hi", hi32, 32'h0);
    check("midrst_lo", lo32, 32'h0);
    reset = 1'b0;
    for (int i = 0; i < 2; i++) begin
      hi_m[i] = 32'h0; lo_m[i] = 32'h0;
    end
    tick();
    check("midrst_no_done", {31'h0, done32}, 32'h0);
    check("midrst_idle", {31'h0, busy32}, 32'h0);
    $display("reset mid-multiply busy=%b done=%b hi=%h lo=%h", busy32, done32, hi32, lo32);

    // 8-bit instance
    run_op(1'b1, 4'h9, 32'hFF, 32'hFF, 0);
    check("mul8_hi", {24'h0, hi8}, 32'hFE);
    check("mul8_lo", {24'h0, lo8}, 32'h01);
    run_op(1'b1, 4'hA, 32'd100, 32'd7, 1);
    check("div8_lo", {24'h0, lo8}, 32'd14);
    check("div8_hi", {24'h0, hi8}, 32'd2);

    // Random combinational ops on both widths
    for (int i = 0; i < 40; i++) begin
      logic [31:0] e32, e8;
      alu_c = 4'($urandom_range(0, 15));
      a_in = $urandom; b_in = $urandom;
      if (i % 8 == 0) b_in = a_in;
      #1;
      e32 = exp_alu(1'b0, alu_c, a_in, b_in, hi_m[0], lo_m[0]);
      e8  = exp_alu(1'b1, alu_c, a_in, b_in, hi_m[1], lo_m[1]);
      check("rand_out32", out32, e32);
      check("rand_zero32", {31'h0, zero32}, {31'h0, (e32 == 32'h0)});
      check("rand_out8", {24'h0, out8}, e8);
      check("rand_zero8", {31'h0, zero8}, {31'h0, (e8 == 32'h0)});
      $display("rand alu_c=%h a=%h b=%h out32=%h out8=%h", alu_c, a_in, b_in, out32, out8);
    end
    tick();

    // Random multi-cycle ops on both widths
    for (int i = 0; i < 12; i++) begin
      logic [3:0]  op;
      logic [31:0] a, b;
      op = ($urandom_range(0, 1) == 0) ? 4'h9 : 4'hA;
      a  = $urandom;
      b  = ($urandom_range(0, 4) == 0) ? 32'h0 : $urandom;
      run_op(bit'(i % 2), op, a, b, 0);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule
